demux_1to2_buf: RTL and testbench
=================================

Name: demux_1to2_buf

Overview:
- Registered 1-to-2 stream demultiplexer: the distributing counterpart of the datapath 2-to-1 select mux.
- One producer stream (valid/ready) is steered by a per-beat select bit into one of two consumer lanes.
- Each lane has its own 2-entry FIFO, so a stalled lane never blocks the other lane's queued beats.
- Used wherever one pipeline source feeds two sinks, e.g. splitting results between write-back paths.

Parameters:
- size, 32, data width in bits of data_i, data0_o and data1_o.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- data_i  input  size  producer data.
- select_i  input  1  lane select for the current beat: 0 = lane0, 1 = lane1.
- valid_i  input  1  producer beat valid.
- ready_o  output  1  producer may transfer this cycle.
- data0_o  output  size  lane0 head data.
- valid0_o  output  1  lane0 head valid.
- ready0_i  input  1  lane0 consumer ready.
- data1_o  output  size  lane1 head data.
- valid1_o  output  1  lane1 head valid.
- ready1_i  input  1  lane1 consumer ready.
- count0_o  output  2  lane0 occupancy, 0..2.
- count1_o  output  2  lane1 occupancy, 0..2.

Behaviour:
- Reset (rst_i=0, asynchronous): both FIFOs are flushed and pointers cleared.
  - valid0_o = valid1_o = 0, count0_o = count1_o = 0, data0_o = data1_o = 0.
  - Beats in flight at reset are discarded.
  - On release, the block is ready on the first clock edge.
- ready_o is combinational: ready_o = (select_i ? count1_o != 2 : count0_o != 2).
  - ready_o depends only on the selected lane's fullness.
  - There is no full-and-popping bypass: a full lane keeps ready_o=0 even if it pops in the same cycle.
- Push: when valid_i && ready_o at an edge, data_i is written to the tail of the lane given by select_i.
  - select_i and data_i are sampled only when valid_i=1.
  - Producer rule: data_i and select_i stay stable while valid_i=1 && ready_o=0.
- Pop, lane k: when validk_o && readyk_i at an edge, the head is removed.
  - validk_o = (countk_o != 0).
  - datak_o = head entry.
  - datak_o is don't-care while validk_o=0; the bench does not check it.
- Latency: a beat accepted at edge N is visible on its lane (valid high, data correct) after edge N, i.e. one cycle.
  - There is no combinational path from data_i to datak_o.
- Ordering: strict FIFO order within a lane; no ordering relation between the two lanes.
- Occupancy update per lane per edge: count' = count + push − pop.
  - Simultaneous push and pop at count 1 leaves count at 1, the head advances, and the new beat becomes the tail.
  - Simultaneous push and pop at count 0 is impossible, because pop requires valid.
- Storage: each lane is two entries with 1-bit read and write pointers that wrap 1→0.
  - Pointers advance only on pop and push respectively.
- The two lanes are fully independent. A push to one lane and a pop from the other lane in the same cycle are both honoured.
- readyk_i asserted while validk_o=0 has no effect.
- No state machine beyond the two FIFO pointer/count sets. Counts never exceed 2 or go below 0.

Test Plan (size=32):
- Reset then idle -> valid0_o=0, valid1_o=0, count0_o=0, count1_o=0, ready_o=1 for either select_i.
- Push 0x11111111 (sel 0), then 0x22222222 (sel 1), with ready0_i=ready1_i=1.
  - Required: data0_o=0x11111111 valid one cycle after its accept edge.
  - Required: data1_o=0x22222222 valid one cycle after its accept edge.
  - Required: each is popped exactly once.
- Hold ready0_i=0 and push 0xA0, 0xA1 to lane0.
  - Required: count0_o=2 and ready_o=0 with select_i=0.
  - Required: ready_o=1 with select_i=1, and 0xB0 pushed to lane1 pops normally.
- With lane0 full, assert ready0_i=1 while offering 0xA2 on select_i=0.
  - Required: ready_o stays 0 that cycle and count0_o=1 next cycle.
  - Required: 0xA2 is then accepted and the lane0 output order is 0xA0, 0xA1, 0xA2.
- Lane1 at count 1; push 0xC1 and pop the head in the same cycle.
  - Required: count1_o stays 1, data1_o=0xC1 next cycle, and pointers wrap correctly across 4 such cycles.
- Fill both lanes, then drop rst_i mid-cycle.
  - Required: valid0_o, valid1_o and both counts go 0 immediately without waiting for a clock edge.
  - Required: after release, the first pushed beat 0x5A5A5A5A emerges alone on its lane.

Source files
------------

// File: rtl/demux_1to2_buf.sv
// Registered 1-to-2 stream demultiplexer.
// A single valid/ready producer is steered beat-by-beat into one of two
// consumer lanes. Each lane owns a 2-entry FIFO, so back-pressure on one lane
// never holds up beats already queued for, or headed to, the other lane.

// One 2-entry FIFO lane: 1-bit read/write pointers and a 0..2 occupancy count.
module demux_1to2_lane #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [size-1:0] push_data,
    input  logic            ready,
    output logic            valid,
    output logic [size-1:0] data,
    output logic [1:0]      count
);

    logic [size-1:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            full;
    logic            push_fire;
    logic            pop_fire;
    logic [1:0]      count_next;

    // The head is valid whenever anything is stored; the consumer pops it
    // only when it is both valid and accepted, so a stray ready while empty
    // does nothing.
    assign full      = (count == 2'd2);
    assign valid     = (count != 2'd0);
    assign push_fire = push && !full;
    assign pop_fire  = valid && ready;

    // Head entry is driven straight from storage; there is no path from the
    // producer data to this output, so a new beat shows up one edge later.
    assign data = mem[rd_ptr];

    // Occupancy update: count' = count + push - pop.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        count_next = count;
        unique case ({push_fire, pop_fire})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Storage, pointers and count; pointers advance only on their own event
    // and wrap 1->0 naturally because they are a single bit wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage words are cleared on reset so the lane data outputs read 0 out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (push_fire) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

endmodule

// Top level: steers the producer into lane0 or lane1 by select_i.
module demux_1to2_buf #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic            select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [size-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i,
    output logic [1:0]      count0_o,
    output logic [1:0]      count1_o
);

    logic accept;
    logic push0;
    logic push1;

    // Ready looks only at the selected lane's fullness. A full lane that is
    // popping in the same cycle still reports not-ready: no bypass path.
    assign ready_o = select_i ? (count1_o != 2'd2) : (count0_o != 2'd2);
    assign accept  = valid_i && ready_o;
    assign push0   = accept && !select_i;
    assign push1   = accept &&  select_i;

    demux_1to2_lane #(.size(size)) u_lane0 (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (push0),
        .push_data (data_i),
        .ready     (ready0_i),
        .valid     (valid0_o),
        .data      (data0_o),
        .count     (count0_o)
    );

    demux_1to2_lane #(.size(size)) u_lane1 (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (push1),
        .push_data (data_i),
        .ready     (ready1_i),
        .valid     (valid1_o),
        .data      (data1_o),
        .count     (count1_o)
    );

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Directed testbench for demux_1to2_buf (size = 32).
module tb_demux_1to2_buf;

    localparam int size = 32;

    logic            clk_i;
    logic            rst_i;
    logic [size-1:0] data_i;
    logic            select_i;
    logic            valid_i;
    logic            ready_o;
    logic [size-1:0] data0_o;
    logic            valid0_o;
    logic            ready0_i;
    logic [size-1:0] data1_o;
    logic            valid1_o;
    logic            ready1_i;
    logic [1:0]      count0_o;
    logic [1:0]      count1_o;

    int vectors;
    int miscompares;

    demux_1to2_buf #(.size(size)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i),
        .count0_o (count0_o),
        .count1_o (count1_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Compare lane0 state against expected count/valid/data (data only when valid).
    task automatic expect_lane0(input string name, input logic [1:0] cnt, input logic [size-1:0] dat);
        vectors++;
        if (count0_o !== cnt) begin
            $display("FAIL %s count0_o got %0d want %0d", name, count0_o, cnt);
            miscompares++;
        end
        vectors++;
        if (valid0_o !== (cnt != 2'd0)) begin
            $display("FAIL %s valid0_o got %b want %b", name, valid0_o, cnt != 2'd0);
            miscompares++;
        end
        if (cnt != 2'd0) begin
            vectors++;
            if (data0_o !== dat) begin
                $display("FAIL %s data0_o got %h want %h", name, data0_o, dat);
                miscompares++;
            end
        end
    endtask

    // Compare lane1 state against expected count/valid/data (data only when valid).
    task automatic expect_lane1(input string name, input logic [1:0] cnt, input logic [size-1:0] dat);
        vectors++;
        if (count1_o !== cnt) begin
            $display("FAIL %s count1_o got %0d want %0d", name, count1_o, cnt);
            miscompares++;
        end
        vectors++;
        if (valid1_o !== (cnt != 2'd0)) begin
            $display("FAIL %s valid1_o got %b want %b", name, valid1_o, cnt != 2'd0);
            miscompares++;
        end
        if (cnt != 2'd0) begin
            vectors++;
            if (data1_o !== dat) begin
                $display("FAIL %s data1_o got %h want %h", name, data1_o, dat);
                miscompares++;
            end
        end
    endtask

    task automatic expect_ready(input string name, input logic want);
        vectors++;
        if (ready_o !== want) begin
            $display("FAIL %s ready_o got %b want %b", name, ready_o, want);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b0;
        valid_i  = 1'b0;
        select_i = 1'b0;
        data_i   = '0;
        ready0_i = 1'b0;
        ready1_i = 1'b0;
        #2;
        vectors++;
        if (data0_o !== 32'h0 || data1_o !== 32'h0) begin
            $display("FAIL reset_data data0_o=%h data1_o=%h want 0", data0_o, data1_o);
            miscompares++;
        end
        expect_lane0("reset_l0", 2'd0, '0);
        expect_lane1("reset_l1", 2'd0, '0);
        #10 rst_i = 1'b1;
        step();
        select_i = 1'b0;
        #1 expect_ready("idle_sel0", 1'b1);
        select_i = 1'b1;
        #1 expect_ready("idle_sel1", 1'b1);
        expect_lane0("idle_l0", 2'd0, '0);
        expect_lane1("idle_l1", 2'd0, '0);
    endtask

    task automatic test_basic();
        ready0_i = 1'b1;
        ready1_i = 1'b1;
        valid_i  = 1'b1;
        select_i = 1'b0;
        data_i   = 32'h1111_1111;
        #1 expect_ready("basic_rdy0", 1'b1);
        step();
        select_i = 1'b1;
        data_i   = 32'h2222_2222;
        expect_lane0("basic_l0_head", 2'd1, 32'h1111_1111);
        expect_lane1("basic_l1_empty", 2'd0, '0);
        step();
        valid_i = 1'b0;
        expect_lane0("basic_l0_popped", 2'd0, '0);
        expect_lane1("basic_l1_head", 2'd1, 32'h2222_2222);
        step();
        expect_lane1("basic_l1_popped", 2'd0, '0);
        expect_lane0("basic_l0_once", 2'd0, '0);
    endtask

    task automatic test_lane0_full();
        ready0_i = 1'b0;
        ready1_i = 1'b1;
        valid_i  = 1'b1;
        select_i = 1'b0;
        data_i   = 32'hA0;
        step();
        expect_lane0("full_a0", 2'd1, 32'hA0);
        data_i = 32'hA1;
        step();
        expect_lane0("full_a1", 2'd2, 32'hA0);
        #1 expect_ready("full_sel0", 1'b0);
        select_i = 1'b1;
        data_i   = 32'hB0;
        #1 expect_ready("full_sel1", 1'b1);
        step();
        expect_lane1("full_b0", 2'd1, 32'hB0);
        expect_lane0("full_hold", 2'd2, 32'hA0);
        // Lane0 full and popping: still not ready for A2.
        select_i = 1'b0;
        data_i   = 32'hA2;
        ready0_i = 1'b1;
        #1 expect_ready("full_nobypass", 1'b0);
        step();
        expect_lane0("full_pop_a0", 2'd1, 32'hA1);
        expect_lane1("full_b0_popped", 2'd0, '0);
        #1 expect_ready("full_a2_ready", 1'b1);
        step();
        valid_i = 1'b0;
        expect_lane0("full_a2_in", 2'd1, 32'hA2);
        step();
        expect_lane0("full_drain", 2'd0, '0);
    endtask

    task automatic test_push_pop_same();
        logic [size-1:0] beats [5];
        beats[0] = 32'hC0;
        beats[1] = 32'hC1;
        beats[2] = 32'hC2;
        beats[3] = 32'hC3;
        beats[4] = 32'hC4;
        ready1_i = 1'b0;
        valid_i  = 1'b1;
        select_i = 1'b1;
        data_i   = beats[0];
        step();
        expect_lane1("pp_seed", 2'd1, beats[0]);
        ready1_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            data_i = beats[i];
            #1 expect_ready("pp_ready", 1'b1);
            step();
            expect_lane1("pp_cycle", 2'd1, beats[i]);
        end
        valid_i = 1'b0;
        step();
        expect_lane1("pp_drain", 2'd0, '0);
    endtask

    task automatic test_reset_mid();
        ready0_i = 1'b0;
        ready1_i = 1'b0;
        valid_i  = 1'b1;
        select_i = 1'b0;
        data_i   = 32'hD0;
        step();
        data_i = 32'hD1;
        step();
        select_i = 1'b1;
        data_i   = 32'hE0;
        step();
        data_i = 32'hE1;
        step();
        valid_i = 1'b0;
        expect_lane0("mid_fill0", 2'd2, 32'hD0);
        expect_lane1("mid_fill1", 2'd2, 32'hE0);
        #2 rst_i = 1'b0;
        #1;
        expect_lane0("mid_rst0", 2'd0, '0);
        expect_lane1("mid_rst1", 2'd0, '0);
        #1 rst_i = 1'b1;
        valid_i  = 1'b1;
        select_i = 1'b0;
        data_i   = 32'h5A5A_5A5A;
        step();
        valid_i  = 1'b0;
        ready0_i = 1'b1;
        expect_lane0("mid_first", 2'd1, 32'h5A5A_5A5A);
        expect_lane1("mid_l1_empty", 2'd0, '0);
        step();
        expect_lane0("mid_alone", 2'd0, '0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_lane0_full();
        test_push_pop_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
